md5_step_sequencer: RTL and testbench

//  Iterative MD5 compression engine for one 512-bit padded block, using a single shared round-step datapath.

---
 rtl/md5_pkg.sv | 64 ++++++
 rtl/pancham_round.sv | 35 +++
 rtl/md5_step_sequencer.sv | 97 +++++++++
 tb/tb_md5_step_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Constants shared by the MD5 step sequencer: IV, per-step rotate and sine tables,
// round encodings, FSM state codes and the message word index function.
package md5_pkg;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;
    localparam logic [127:0] IV  = {IV_D, IV_C, IV_B, IV_A};

    localparam logic [1:0] ROUND1 = 2'd0;
    localparam logic [1:0] ROUND2 = 2'd1;
    localparam logic [1:0] ROUND3 = 2'd2;
    localparam logic [1:0] ROUND4 = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FINAL = 2'd2;

    localparam logic [4:0] S_TABLE [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    localparam logic [31:0] T_TABLE [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // 4-bit arithmetic gives the mod-16 wrap for free.
    function automatic logic [3:0] g_index(input logic [5:0] step);
        logic [3:0] k;
        logic [3:0] g;
        k = step[3:0];
        case (step[5:4])
            ROUND1:  g = k;
            ROUND2:  g = k * 4'd5 + 4'd1;
            ROUND3:  g = k * 4'd3 + 4'd5;
            default: g = k * 4'd7;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/pancham_round.sv
// Combinational MD5 round step: next_a = b + rotl(a + F(b,c,d) + m + t, s).
module pancham_round
    import md5_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] m,
    input  logic [31:0] t,
    input  logic [4:0]  s,
    input  logic [1:0]  round,
    output logic [31:0] next_a
);

    logic [31:0] f;
    logic [31:0] sum;
    logic [63:0] rot;

    always_comb begin
        f = 32'd0;
        case (round)
            ROUND1:  f = (b & c) | (~b & d);
            ROUND2:  f = (d & b) | (~d & c);
            ROUND3:  f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
    end

    assign sum = a + f + m + t;
    // Upper half of the doubled word shifted left is the left rotate.
    assign rot    = {sum, sum} << s;
    assign next_a = b + rot[63:32];

endmodule

// File: rtl/md5_step_sequencer.sv
// Iterative MD5 compression of one 512-bit block, one round step per clock.
// Define MD5_CHAIN_EN to add msg_first and chain multi-block messages.
module md5_step_sequencer
    import md5_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] msg_in,
    input  logic         msg_in_valid,
`ifdef MD5_CHAIN_EN
    input  logic         msg_first,
`endif
    output logic         ready,
    output logic [127:0] digest,
    output logic         digest_valid
);

    logic [1:0]   state;
    logic [5:0]   step;
    logic [511:0] msg_q;
    logic [31:0]  a, b, c, d;
    logic [127:0] chain;
    logic [3:0]   g;
    logic [31:0]  m_sel;
    logic [31:0]  next_a;
    logic [127:0] sums;

    assign ready = (state == ST_IDLE);
    assign g     = g_index(step);
    assign m_sel = msg_q[{g, 5'd0} +: 32];
    assign sums  = {d + chain[127:96], c + chain[95:64], b + chain[63:32], a + chain[31:0]};

    pancham_round u_round (
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .m      (m_sel),
        .t      (T_TABLE[step]),
        .s      (S_TABLE[step]),
        .round  (step[5:4]),
        .next_a (next_a)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            step         <= 6'd0;
            msg_q        <= '0;
            {d, c, b, a} <= '0;
            chain        <= IV;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            digest_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (msg_in_valid) begin
                        msg_q <= msg_in;
                        step  <= 6'd0;
                        state <= ST_RUN;
`ifdef MD5_CHAIN_EN
                        if (msg_first) begin
                            chain        <= IV;
                            {d, c, b, a} <= IV;
                        end else begin
                            {d, c, b, a} <= chain;
                        end
`else
                        chain        <= IV;
                        {d, c, b, a} <= IV;
`endif
                    end
                end
                ST_RUN: begin
                    a <= d;
                    b <= next_a;
                    c <= b;
                    d <= c;
                    if (step == 6'd63) begin
                        state <= ST_FINAL;
                    end else begin
                        step <= step + 6'd1;
                    end
                end
                ST_FINAL: begin
                    chain        <= sums;
                    digest       <= sums;
                    digest_valid <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_step_sequencer.sv
// Directed bench for md5_step_sequencer: known digests, latency, back-to-back,
// busy drop and mid-block reset; chained blocks when MD5_CHAIN_EN is defined.
module tb_md5_step_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] msg_in = '0;
    logic         msg_in_valid = 1'b0;
`ifdef MD5_CHAIN_EN
    logic         msg_first = 1'b1;
`endif
    logic         ready;
    logic [127:0] digest;
    logic         digest_valid;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] EXP_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] EXP_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;

    md5_step_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .msg_in       (msg_in),
        .msg_in_valid (msg_in_valid),
`ifdef MD5_CHAIN_EN
        .msg_first    (msg_first),
`endif
        .ready        (ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic accept(input logic [511:0] m, input logic first);
        @(negedge clk);
        chk("acc_ready", {127'd0, ready}, 128'd1);
        msg_in       = m;
        msg_in_valid = 1'b1;
`ifdef MD5_CHAIN_EN
        msg_first    = first;
`else
        if (first) msg_in_valid = 1'b1;
`endif
        @(posedge clk);
        @(negedge clk);
        msg_in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until digest_valid is seen; ready must stay low until then.
    task automatic run_to_done(input int garbage_at, output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (digest_valid) break;
            if (ready) busy_ok = 1'b0;
            if (lat == garbage_at) begin
                msg_in       = {16{32'hdeadbeef}};
                msg_in_valid = 1'b1;
            end else if (lat == garbage_at + 1) begin
                msg_in_valid = 1'b0;
            end
        end
    endtask

`ifdef MD5_CHAIN_EN
    localparam logic [31:0] K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int RS [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    function automatic logic [127:0] ref_md5(input logic [127:0] cv, input logic [511:0] m);
        logic [31:0] a, b, c, d, f, x, tmp;
        int g, r;
        a = cv[31:0]; b = cv[63:32]; c = cv[95:64]; d = cv[127:96];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
            r   = RS[(i / 16) * 4 + i % 4];
            x   = a + f + K[i] + m[32 * g +: 32];
            tmp = d; d = c; c = b;
            b   = b + ((x << r) | (x >> (32 - r)));
            a   = tmp;
        end
        return {cv[127:96] + d, cv[95:64] + c, cv[63:32] + b, cv[31:0] + a};
    endfunction
`endif

    initial begin
        logic [511:0] v_empty, v_abc;
        int  lat;
        bit  busy_ok;
        bit  seen_dv;

        v_empty = '0;
        v_empty[31:0] = 32'h00000080;
        v_abc = '0;
        v_abc[31:0]    = 32'h80636261;
        v_abc[479:448] = 32'h00000018;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {127'd0, ready}, 128'd1);
        chk("rst_digest", digest, 128'd0);
        chk("rst_dv", {127'd0, digest_valid}, 128'd0);
        rst = 1'b0;

        // empty string: latency, digest, pulse width, hold
        accept(v_empty, 1'b1);
        run_to_done(-1, lat, busy_ok);
        chk("empty_lat", 128'(lat), 128'd65);
        chk("empty_digest", digest, EXP_EMPTY);
        chk("empty_ready_back", {127'd0, ready}, 128'd1);
        chk("empty_busy", {127'd0, busy_ok}, 128'd1);
        @(negedge clk);
        chk("empty_dv_pulse", {127'd0, digest_valid}, 128'd0);
        chk("empty_hold", digest, EXP_EMPTY);

        accept(v_abc, 1'b1);
        run_to_done(-1, lat, busy_ok);
        chk("abc_lat", 128'(lat), 128'd65);
        chk("abc_digest", digest, EXP_ABC);
        chk("abc_busy", {127'd0, busy_ok}, 128'd1);

        // back-to-back with msg_in_valid held high
        @(negedge clk);
        msg_in = v_empty;
        msg_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        msg_in = v_abc;
        run_to_done(-1, lat, busy_ok);
        chk("b2b1_lat", 128'(lat), 128'd65);
        chk("b2b1_digest", digest, EXP_EMPTY);
        chk("b2b1_ready", {127'd0, ready}, 128'd1);
        chk("b2b1_busy", {127'd0, busy_ok}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        msg_in_valid = 1'b0;
        chk("b2b2_taken", {127'd0, ready}, 128'd0);
        run_to_done(-1, lat, busy_ok);
        chk("b2b2_lat", 128'(lat), 128'd65);
        chk("b2b2_digest", digest, EXP_ABC);

        // garbage offered while busy at step 30
        accept(v_empty, 1'b1);
        run_to_done(30, lat, busy_ok);
        chk("busy_lat", 128'(lat), 128'd65);
        chk("busy_digest", digest, EXP_EMPTY);
        chk("busy_ready_low", {127'd0, busy_ok}, 128'd1);

        // reset at step 40 abandons the block
        accept(v_abc, 1'b1);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", {127'd0, ready}, 128'd1);
        chk("mid_rst_digest", digest, 128'd0);
        chk("mid_rst_dv", {127'd0, digest_valid}, 128'd0);
        seen_dv = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (digest_valid) seen_dv = 1'b1;
        end
        chk("mid_rst_no_dv", {127'd0, seen_dv}, 128'd0);
        accept(v_empty, 1'b1);
        run_to_done(-1, lat, busy_ok);
        chk("post_rst_digest", digest, EXP_EMPTY);

`ifdef MD5_CHAIN_EN
        begin
            logic [511:0] blk1, blk2;
            logic [127:0] h1;
            blk1 = '0;
            blk2 = '0;
            for (int j = 0; j < 14; j++) blk1[32 * j +: 32] = 32'h61616161;
            blk1[479:448] = 32'h00000080;
            blk2[479:448] = 32'h000001c0;
            h1 = ref_md5({32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301}, blk1);

            accept(blk1, 1'b1);
            run_to_done(-1, lat, busy_ok);
            chk("chain_blk1", digest, h1);
            accept(blk2, 1'b0);
            run_to_done(-1, lat, busy_ok);
            chk("chain_blk2", digest, ref_md5(h1, blk2));
            accept(blk2, 1'b1);
            run_to_done(-1, lat, busy_ok);
            chk("chain_restart", digest,
                ref_md5({32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301}, blk2));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
